fsqrt_checker: RTL and testbench
================================

FSQRT_CHECKER -- requirements
Module: fsqrt_checker

Interface
REQ-001 SHALL have parameter LATENCY, default 4: clock edges from the edge sampling x (valid_in=1) to the edge sampling the matching y.
REQ-002 SHALL have parameter TOL, default 4: maximum allowed |bits(y*y) - bits(x)| for a pass, in ULPs.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a checking run.
REQ-006 SHALL have port n_tests, input, 16 bits: number of valid_in samples in the run; sampled on start.
REQ-007 SHALL have port valid_in, input, 1 bit: x is a real operand this cycle.
REQ-008 SHALL have port x, input, 32 bits: IEEE-754 single operand driven into fsqrt.
REQ-009 SHALL have port y, input, 32 bits: fsqrt result.
REQ-010 SHALL have outputs pass_count, fail_count and skip_count, 16 bits each.
REQ-011 SHALL have output err_pulse, 1 bit: one-cycle pulse per failing check.
REQ-012 SHALL have outputs first_err_x and first_err_y, 32 bits each: operand and result of the first failure in the run.
REQ-013 SHALL have output busy, 1 bit: FSM is in RUN or DRAIN.
REQ-014 SHALL have output done, 1 bit: FSM is in DONE.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE->RUN on start; SHALL clear all counters, first_err_*, and the issued count.
REQ-017 In RUN, each valid_in SHALL increment the issued count; RUN->DRAIN when issued reaches n_tests.
REQ-018 valid_in outside RUN SHALL be ignored.
REQ-019 DRAIN->DONE once every issued sample has updated a counter.
REQ-020 DONE->IDLE on start, which SHALL also begin a new run (clear, then RUN).
REQ-021 start in RUN or DRAIN SHALL be ignored.
REQ-022 n_tests=0 SHALL go IDLE->RUN->DRAIN->DONE with no counter change.
REQ-023 x and valid_in SHALL pass through a LATENCY-deep shift register; y SHALL be paired with the delayed x.
REQ-024 Stage A, at the pairing edge, SHALL register y, the delayed x, and its class.
REQ-025 Stage B, one edge later, SHALL register the square result.
REQ-026 Counters and err_pulse SHALL update on the edge after stage B, i.e. LATENCY+2 edges after x is sampled.
REQ-027 Classes: x sign=1 or exponent 255 -> skip (skip_count++).
REQ-028 Classes: x exponent 0 -> pass iff y[30:23]==0, else fail.
REQ-029 Classes: otherwise -> normal check.
REQ-030 Normal check: my={1,y[22:0]}; p=my*my (48 bits); e_sq=2*ey-127+p[47], signed 10-bit.
REQ-031 Normal check mantissa SHALL be p[46:24] if p[47]=1, else p[45:23]; truncated, no rounding.
REQ-032 Normal check: y sign=1, ey=0, ey=255, e_sq<=0 or e_sq>=255 SHALL be a fail.
REQ-033 Otherwise pass iff |{e_sq[7:0],mant} - x[30:0]| <= TOL, as unsigned 31-bit difference.
REQ-034 Each fail SHALL increment fail_count and pulse err_pulse.
REQ-035 On the first fail only, SHALL latch first_err_x and first_err_y.
REQ-036 Counters SHALL saturate at 0xFFFF.
REQ-037 Back-to-back valid_in every cycle SHALL be checked at full throughput.

Reset
REQ-038 rst SHALL override start and valid_in in the same cycle.
REQ-039 rst (including mid-RUN or mid-DRAIN) SHALL set state IDLE, all counters 0, first_err_* 0, err_pulse 0, busy 0, done 0.
REQ-040 rst SHALL clear the delay-line valid bits so in-flight samples are dropped.

Structure
REQ-041 A shared package SHALL hold the state enum, class enum, and constants EXP_BIAS=127 and EXP_MAX=255.
REQ-042 Squarer (REQ-030/REQ-031, with the out-of-range flag) SHALL be sub-module fsquare, combinational, registered by the checker in stage B.

Verification
REQ-043 start, n_tests=1; x=0x40800000, y=0x40000000 -> pass_count=1, done=1 at edge LATENCY+3 after x.
REQ-044 x=0x40800000, y=0x40000001 -> pass (distance 2); y=0x40100000 -> fail_count=1, err_pulse=1, first_err_y=0x40100000.
REQ-045 x=0xBF800000 -> skip_count=1; x=0, y=0 -> pass; x=0, y=0x00800000 -> fail.
REQ-046 n_tests=3, three consecutive valid_in with two failures -> fail_count=2, first_err_* = first failure, counters final 2 cycles after the third y.
REQ-047 rst asserted during RUN with samples in flight -> all outputs 0, IDLE, no later counter update.
REQ-048 start while busy ignored; valid_in in IDLE/DONE -> counters unchanged.

Source files
------------

// File: rtl/fsqrt_checker_pkg.sv
// Shared types and constants for the fsqrt result checker.
package fsqrt_checker_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_SKIP,
        CLS_ZERO,
        CLS_NORM
    } cls_t;

    // Negative operands, infinities and NaNs are not checked; zero/denormal
    // operands only need a zero-exponent result.
    function automatic cls_t classify(input logic [31:0] v);
        if (v[31] || (v[30:23] == 8'(EXP_MAX))) begin
            return CLS_SKIP;
        end
        if (v[30:23] == 8'd0) begin
            return CLS_ZERO;
        end
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fsqrt_checker_fsquare.sv
// Combinational single-precision squarer: truncated mantissa, rebiased
// exponent, and a flag for results that cannot be compared as normals.
module fsquare
    import fsqrt_checker_pkg::*;
(
    input  logic [31:0] i_y,
    output logic [30:0] o_sq,
    output logic        o_bad
);

    logic        [23:0] w_my;
    logic        [47:0] w_p;
    logic signed [9:0]  w_e_sq;
    logic        [22:0] w_mant;

    // Square the mantissa, renormalise on the product's top bit.
    always_comb begin
        w_my   = {1'b1, i_y[22:0]};
        w_p    = 48'(w_my) * 48'(w_my);
        w_e_sq = $signed({1'b0, i_y[30:23], 1'b0})
               - $signed(10'(EXP_BIAS))
               + $signed({9'd0, w_p[47]});
        w_mant = w_p[47] ? w_p[46:24] : w_p[45:23];
        o_sq   = {w_e_sq[7:0], w_mant};
        o_bad  = i_y[31]
              || (i_y[30:23] == 8'd0)
              || (i_y[30:23] == 8'(EXP_MAX))
              || (w_e_sq <= 10'sd0)
              || (w_e_sq >= 10'sd255);
    end

endmodule

// File: rtl/fsqrt_checker.sv
// Streaming checker for an fsqrt unit: pairs each operand with the result
// LATENCY edges later, squares the result and compares against the operand.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | accepting valid_in samples until n_tests issued
// ST_DRAIN | waiting for issued samples to reach the counters
// ST_DONE  | counters final; start begins a new run
module fsqrt_checker
    import fsqrt_checker_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int TOL     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n_tests,
    input  logic        valid_in,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic [15:0] skip_count,
    output logic        err_pulse,
    output logic [31:0] first_err_x,
    output logic [31:0] first_err_y,
    output logic        busy,
    output logic        done
);

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_n_tests, r_issued, r_retired;
    logic [31:0]   r_x_dl [LATENCY];
    logic [LATENCY-1:0] r_v_dl;

    logic          r_a_v, r_b_v;
    logic [31:0]   r_a_x, r_a_y, r_b_x, r_b_y;
    cls_t          r_a_cls, r_b_cls;
    logic [30:0]   r_b_sq;
    logic          r_b_bad;

    logic [15:0]   r_pass, r_fail, r_skip;
    logic          r_err_pulse;
    logic [31:0]   r_first_x, r_first_y;

    logic          w_accept, w_start_run;
    logic [30:0]   w_sq, w_dist;
    logic          w_bad, w_is_pass, w_is_fail, w_is_skip;

    assign w_accept    = (r_state == ST_RUN) && valid_in && (r_issued != r_n_tests);
    assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the last accepted sample moves RUN to DRAIN directly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if ((r_issued == r_n_tests) ||
                          (w_accept && ((r_issued + 16'd1) == r_n_tests)))
                          w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_retired == r_issued) w_state_nxt = ST_DONE;
            ST_DONE:  if (start) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand delay line matching the fsqrt latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_dl <= '0;
        end else begin
            r_v_dl[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_v_dl[i] <= r_v_dl[i-1];
            end
        end
        r_x_dl[0] <= x;
        for (int i = 1; i < LATENCY; i++) begin
            r_x_dl[i] <= r_x_dl[i-1];
        end
    end

    fsquare u_fsquare (
        .i_y   (r_a_y),
        .o_sq  (w_sq),
        .o_bad (w_bad)
    );

    // Stage A pairs y with its operand; stage B holds the squared result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_v <= 1'b0;
            r_b_v <= 1'b0;
        end else begin
            r_a_v <= r_v_dl[LATENCY-1];
            r_b_v <= r_a_v;
        end
        r_a_x   <= r_x_dl[LATENCY-1];
        r_a_y   <= y;
        r_a_cls <= classify(r_x_dl[LATENCY-1]);
        r_b_x   <= r_a_x;
        r_b_y   <= r_a_y;
        r_b_cls <= r_a_cls;
        r_b_sq  <= w_sq;
        r_b_bad <= w_bad;
    end

    // Verdict for the sample leaving stage B.
    always_comb begin
        w_dist    = (r_b_sq >= r_b_x[30:0]) ? (r_b_sq - r_b_x[30:0])
                                            : (r_b_x[30:0] - r_b_sq);
        w_is_pass = 1'b0;
        w_is_fail = 1'b0;
        w_is_skip = 1'b0;
        if (r_b_v) begin
            case (r_b_cls)
                CLS_SKIP: w_is_skip = 1'b1;
                CLS_ZERO: if (r_b_y[30:23] == 8'd0) w_is_pass = 1'b1;
                          else w_is_fail = 1'b1;
                default:  if (!r_b_bad && (w_dist <= 31'(TOL))) w_is_pass = 1'b1;
                          else w_is_fail = 1'b1;
            endcase
        end
    end

    // Run bookkeeping, saturating counters and first-failure capture.
    always_ff @(posedge clk) begin
        if (rst || w_start_run) begin
            r_issued    <= '0;
            r_retired   <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_skip      <= '0;
            r_err_pulse <= 1'b0;
            r_first_x   <= '0;
            r_first_y   <= '0;
            if (!rst) begin
                r_n_tests <= n_tests;
            end
        end else begin
            r_err_pulse <= w_is_fail;
            if (w_accept) begin
                r_issued <= r_issued + 16'd1;
            end
            if (r_b_v) begin
                r_retired <= r_retired + 16'd1;
            end
            if (w_is_pass && (r_pass != 16'hFFFF)) begin
                r_pass <= r_pass + 16'd1;
            end
            if (w_is_skip && (r_skip != 16'hFFFF)) begin
                r_skip <= r_skip + 16'd1;
            end
            if (w_is_fail) begin
                if (r_fail != 16'hFFFF) begin
                    r_fail <= r_fail + 16'd1;
                end
                if (r_fail == 16'd0) begin
                    r_first_x <= r_b_x;
                    r_first_y <= r_b_y;
                end
            end
        end
    end

    assign pass_count  = r_pass;
    assign fail_count  = r_fail;
    assign skip_count  = r_skip;
    assign err_pulse   = r_err_pulse;
    assign first_err_x = r_first_x;
    assign first_err_y = r_first_y;
    assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_fsqrt_checker.sv
// Scoreboard bench for fsqrt_checker: expected verdicts are queued as
// operands are driven and matched against counter updates as they appear.
module tb_fsqrt_checker;

    localparam int LAT = 4;
    localparam int TOL = 4;

    logic        clk = 1'b0;
    logic        rst, start, valid_in;
    logic [15:0] n_tests;
    logic [31:0] x, y;
    logic [15:0] pass_count, fail_count, skip_count;
    logic        err_pulse, busy, done;
    logic [31:0] first_err_x, first_err_y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] xv;
        logic [31:0] yv;
        int          due;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] yv;
    } sched_t;

    exp_t        sb[$];
    logic [31:0] qx[$];
    logic [31:0] qy[$];

    always #5 clk = ~clk;

    fsqrt_checker #(.LATENCY(LAT), .TOL(TOL)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .n_tests     (n_tests),
        .valid_in    (valid_in),
        .x           (x),
        .y           (y),
        .pass_count  (pass_count),
        .fail_count  (fail_count),
        .skip_count  (skip_count),
        .err_pulse   (err_pulse),
        .first_err_x (first_err_x),
        .first_err_y (first_err_y),
        .busy        (busy),
        .done        (done)
    );

    // {bad, exponent[7:0], mantissa[22:0]} of y*y, truncated.
    function automatic logic [31:0] model_sq(input logic [31:0] yv);
        logic [47:0] p;
        logic [47:0] m48;
        int          esq;
        logic [22:0] m;
        logic        bad;
        m48 = {24'd0, 1'b1, yv[22:0]};
        p   = m48 * m48;
        esq = 2 * int'(yv[30:23]) - 127 + int'(p[47]);
        m   = p[47] ? p[46:24] : p[45:23];
        bad = yv[31] || (yv[30:23] == 8'd0) || (yv[30:23] == 8'hFF) || (esq <= 0) || (esq >= 255);
        return {bad, esq[7:0], m};
    endfunction

    // 0 = pass, 1 = fail, 2 = skip
    function automatic int model_kind(input logic [31:0] xv, input logic [31:0] yv);
        logic [31:0] s;
        logic [30:0] d;
        if (xv[31] || (xv[30:23] == 8'hFF)) return 2;
        if (xv[30:23] == 8'd0) return (yv[30:23] == 8'd0) ? 0 : 1;
        s = model_sq(yv);
        if (s[31]) return 1;
        d = (s[30:0] >= xv[30:0]) ? (s[30:0] - xv[30:0]) : (xv[30:0] - s[30:0]);
        return (d <= 31'(TOL)) ? 0 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n);
        start   = 1'b1;
        n_tests = 16'(n);
        tick();
        start   = 1'b0;
    endtask

    task automatic run_batch(input string name, input int gap, input logic [31:0] start_mask);
        int          n, k, last_issue, done_edge, total, exp_done, obs;
        int          prev_p, prev_f, prev_s, dp, df, ds;
        int          exp_cnt[3];
        logic [31:0] exp_fx, exp_fy;
        bit          have_fail;
        exp_t        e;
        sched_t      ys[$];
        n = qx.size();
        k = 0; last_issue = -1; done_edge = -1;
        prev_p = 0; prev_f = 0; prev_s = 0;
        exp_cnt = '{0, 0, 0};
        exp_fx = '0; exp_fy = '0; have_fail = 1'b0;
        total = n * gap + LAT + 6;
        for (int c = 0; c < total; c++) begin
            start = (c < 32) ? start_mask[c] : 1'b0;
            if ((k < n) && ((c % gap) == 0)) begin
                valid_in = 1'b1;
                x        = qx[k];
                e.kind   = model_kind(qx[k], qy[k]);
                e.xv     = qx[k];
                e.yv     = qy[k];
                e.due    = c + LAT + 2;
                sb.push_back(e);
                exp_cnt[e.kind]++;
                if ((e.kind == 1) && !have_fail) begin
                    have_fail = 1'b1;
                    exp_fx    = qx[k];
                    exp_fy    = qy[k];
                end
                ys.push_back('{c + LAT, qy[k]});
                last_issue = c;
                k++;
            end else begin
                valid_in = 1'b0;
                x        = $urandom;
            end
            if ((ys.size() > 0) && (ys[0].cyc == c)) begin
                y = ys[0].yv;
                void'(ys.pop_front());
            end else begin
                y = $urandom;
            end
            tick();
            dp = int'(pass_count) - prev_p;
            df = int'(fail_count) - prev_f;
            ds = int'(skip_count) - prev_s;
            checks++;
            if (err_pulse !== (df == 1)) begin
                errors++;
                $display("FAIL %s err_pulse cycle %0d: got %0b expected %0b", name, c, err_pulse, (df == 1));
            end
            if ((dp != 0) || (df != 0) || (ds != 0)) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected update cycle %0d: dp=%0d df=%0d ds=%0d expected none", name, c, dp, df, ds);
                end else begin
                    e = sb.pop_front();
                    if      (dp == 1 && df == 0 && ds == 0) obs = 0;
                    else if (df == 1 && dp == 0 && ds == 0) obs = 1;
                    else if (ds == 1 && dp == 0 && df == 0) obs = 2;
                    else                                    obs = -1;
                    if ((obs != e.kind) || (c != e.due)) begin
                        errors++;
                        $display("FAIL %s verdict x=%h y=%h: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                                 name, e.xv, e.yv, obs, c, e.kind, e.due);
                    end
                end
            end
            prev_p = int'(pass_count);
            prev_f = int'(fail_count);
            prev_s = int'(skip_count);
            if ((done === 1'b1) && (done_edge < 0)) done_edge = c;
        end
        valid_in = 1'b0;
        start    = 1'b0;
        exp_done = (n == 0) ? 1 : last_issue + LAT + 3;
        checks++;
        if (done_edge != exp_done) begin
            errors++;
            $display("FAIL %s done edge: got %0d expected %0d", name, done_edge, exp_done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing updates: got %0d outstanding expected 0", name, sb.size());
        end
        sb.delete();
        checks++;
        if ((pass_count !== 16'(exp_cnt[0])) || (fail_count !== 16'(exp_cnt[1])) || (skip_count !== 16'(exp_cnt[2]))) begin
            errors++;
            $display("FAIL %s final counts: got %0d/%0d/%0d expected %0d/%0d/%0d", name,
                     pass_count, fail_count, skip_count, exp_cnt[0], exp_cnt[1], exp_cnt[2]);
        end
        checks++;
        if ((first_err_x !== exp_fx) || (first_err_y !== exp_fy)) begin
            errors++;
            $display("FAIL %s first_err: got %h/%h expected %h/%h", name, first_err_x, first_err_y, exp_fx, exp_fy);
        end
        checks++;
        if ((done !== 1'b1) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL %s end state: got done=%0b busy=%0b expected done=1 busy=0", name, done, busy);
        end
        qx.delete();
        qy.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; n_tests = '0; x = '0; y = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({pass_count, fail_count, skip_count} !== 48'd0) begin
            errors++;
            $display("FAIL reset counters: got %h expected 0", {pass_count, fail_count, skip_count});
        end
        checks++;
        if ({err_pulse, busy, done, first_err_x, first_err_y} !== 67'd0) begin
            errors++;
            $display("FAIL reset flags: got %h expected 0", {err_pulse, busy, done, first_err_x, first_err_y});
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; start = 1'b1; valid_in = 1'b1; n_tests = 16'd1;
        tick();
        rst = 1'b0; start = 1'b0; valid_in = 1'b0;
        repeat (LAT + 4) tick();
        checks++;
        if ((busy !== 1'b0) || (done !== 1'b0) || (pass_count !== 16'd0)) begin
            errors++;
            $display("FAIL reset priority: got busy=%0b done=%0b pass=%0d expected 0/0/0", busy, done, pass_count);
        end
    endtask

    task automatic test_single();
        pulse_start(1);
        qx = '{32'h40800000}; qy = '{32'h40000000};
        run_batch("single_pass", 1, 32'h0);
    endtask

    task automatic test_ulp();
        pulse_start(1);
        qx = '{32'h40800000}; qy = '{32'h40000001};
        run_batch("ulp_pass", 1, 32'h0);
        pulse_start(1);
        qx = '{32'h40800000}; qy = '{32'h40100000};
        run_batch("ulp_fail", 1, 32'h0);
    endtask

    task automatic test_classes();
        pulse_start(3);
        qx = '{32'hBF800000, 32'h00000000, 32'h00000000};
        qy = '{32'h12345678, 32'h00000000, 32'h00800000};
        run_batch("classes", 2, 32'h0);
    endtask

    task automatic test_back_to_back();
        pulse_start(3);
        qx = '{32'h40800000, 32'h40800000, 32'h00000000};
        qy = '{32'h40000000, 32'h40100000, 32'h00800000};
        run_batch("back_to_back", 1, 32'h0);
    endtask

    task automatic test_zero_tests();
        pulse_start(0);
        run_batch("zero_tests", 1, 32'h0);
    endtask

    task automatic gen_random(input int n);
        int          r, off;
        logic [7:0]  ey;
        logic [31:0] yv, s;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                qx.push_back({1'b1, 31'($urandom)});
                qy.push_back($urandom);
            end else if (r == 1) begin
                qx.push_back({1'b0, 8'hFF, 23'($urandom)});
                qy.push_back($urandom);
            end else if (r == 2) begin
                qx.push_back({1'b0, 8'h00, 23'($urandom)});
                if ($urandom_range(0, 1) == 0) qy.push_back({1'b0, 8'h00, 23'($urandom)});
                else qy.push_back({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)});
            end else if (r == 3) begin
                qx.push_back({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)});
                qy.push_back({1'b1, 8'($urandom_range(64, 190)), 23'($urandom)});
            end else begin
                ey  = 8'($urandom_range(64, 190));
                yv  = {1'b0, ey, 23'($urandom)};
                s   = model_sq(yv);
                off = int'($urandom_range(0, 16)) - 8;
                qx.push_back(32'(int'({1'b0, s[30:0]}) + off));
                qy.push_back(yv);
            end
        end
    endtask

    task automatic test_random();
        pulse_start(40);
        gen_random(40);
        run_batch("random_b2b", 1, 32'h0);
        pulse_start(10);
        gen_random(10);
        run_batch("random_gap", 3, 32'h0);
    endtask

    task automatic test_ignored();
        pulse_start(2);
        n_tests = 16'd7;
        qx = '{32'h40800000, 32'h00000000};
        qy = '{32'h40000000, 32'h00800000};
        run_batch("start_ignored", 2, 32'h00000012);
        for (int c = 0; c < 6; c++) begin
            valid_in = 1'b1; x = 32'h00000000; y = 32'h00800000;
            tick();
            checks++;
            if ((pass_count !== 16'd1) || (fail_count !== 16'd1) || (skip_count !== 16'd0) || (done !== 1'b1)) begin
                errors++;
                $display("FAIL valid in done cycle %0d: got %0d/%0d/%0d done=%0b expected 1/1/0 done=1",
                         c, pass_count, fail_count, skip_count, done);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_midrun();
        pulse_start(4);
        for (int c = 0; c <= LAT + 2; c++) begin
            valid_in = (c < 3);
            x = (c == 0) ? 32'h00000000 : 32'h40800000;
            y = (c == LAT) ? 32'h00800000 : 32'h40000000;
            tick();
        end
        checks++;
        if ((fail_count !== 16'd1) || (first_err_y !== 32'h00800000) || (busy !== 1'b1)) begin
            errors++;
            $display("FAIL midrun pre-reset: got fail=%0d fy=%h busy=%0b expected 1/00800000/1", fail_count, first_err_y, busy);
        end
        rst = 1'b1; valid_in = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        for (int c = 0; c < LAT + 6; c++) begin
            valid_in = 1'b1; x = 32'h40800000; y = 32'h40000000;
            checks++;
            if ({pass_count, fail_count, skip_count, err_pulse, busy, done, first_err_x, first_err_y} !== 115'd0) begin
                errors++;
                $display("FAIL midrun reset cycle %0d: got p=%0d f=%0d s=%0d e=%0b b=%0b d=%0b fx=%h fy=%h expected all 0",
                         c, pass_count, fail_count, skip_count, err_pulse, busy, done, first_err_x, first_err_y);
            end
            tick();
        end
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_priority();
        test_single();
        test_ulp();
        test_classes();
        test_back_to_back();
        test_zero_tests();
        test_random();
        test_ignored();
        test_reset_midrun();
        test_single();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
